// File: rtl/oam_dma_if.sv
`default_nettype none
// ============================================================================
//  Module      : oam_dma_if
//  Description : CPU-side, memory-side and ppu-register-side bus bundle for
//                the sprite DMA engine.
//  Revision    : 1.0  initial release
// ============================================================================
interface oam_dma_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_i;
  logic        cpu_wr;
  logic        cpu_rdy;
  logic [15:0] dma_addr;
  logic        dma_rd;
  logic [7:0]  dma_data_i;
  logic        ppu_cs;
  logic        ppu_rw;
  logic [2:0]  ppu_addr;
  logic [7:0]  ppu_data_o;
  logic        busy;
  logic        done;

  // master: the DMA engine; slave: the surrounding CPU/memory/ppu system
  modport master (
    input  cpu_addr, cpu_data_i, cpu_wr, dma_data_i,
    output cpu_rdy, dma_addr, dma_rd, ppu_cs, ppu_rw, ppu_addr, ppu_data_o,
           busy, done
  );

  modport slave (
    output cpu_addr, cpu_data_i, cpu_wr, dma_data_i,
    input  cpu_rdy, dma_addr, dma_rd, ppu_cs, ppu_rw, ppu_addr, ppu_data_o,
           busy, done
  );
endinterface
`default_nettype wire

// File: rtl/oam_dma.sv
`default_nettype none
// ============================================================================
//  Module      : oam_dma
//  Description : Sprite DMA engine. A CPU write to the DMA register halts the
//                CPU and copies one page of CPU memory into OAM via OAMDATA.
//  Revision    : 1.0  initial release
// ============================================================================
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter logic [2:0]  OAMDATA_IDX  = 3'd4,
  parameter int          XFER_LEN     = 256
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  oam_dma_if.master  bus
);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_halt  = 3'd1;
  localparam logic [2:0] c_st_align = 3'd2;
  localparam logic [2:0] c_st_read  = 3'd3;
  localparam logic [2:0] c_st_write = 3'd4;
  localparam logic [2:0] c_st_done  = 3'd5;

  localparam logic [7:0] c_last_cnt = 8'(XFER_LEN - 1);

  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] r_page;
  logic [7:0] r_last_data;
  logic       r_parity;
  logic       w_trigger;
  logic       w_last_byte;

  assign w_trigger   = bus.cpu_wr && (bus.cpu_addr == DMA_REG_ADDR);
  assign w_last_byte = (r_cnt == c_last_cnt);

  // State register plus the small datapath that travels with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_st_idle;
      r_cnt       <= '0;
      r_page      <= '0;
      r_last_data <= '0;
      r_parity    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_parity <= ~r_parity;
      if ((r_state == c_st_idle) && w_trigger) begin
        r_page <= bus.cpu_data_i;
        r_cnt  <= '0;
      end
      if (r_state == c_st_write) begin
        r_last_data <= bus.dma_data_i;
        r_cnt       <= w_last_byte ? 8'd0 : r_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (w_trigger) w_state_nxt = c_st_halt;
      // A HALT on an even cycle would put READ on an odd one; pad by one
      c_st_halt:  w_state_nxt = r_parity ? c_st_read : c_st_align;
      c_st_align: w_state_nxt = c_st_read;
      c_st_read:  w_state_nxt = c_st_write;
      c_st_write: w_state_nxt = w_last_byte ? c_st_done : c_st_read;
      c_st_done:  w_state_nxt = c_st_idle;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    bus.cpu_rdy    = 1'b1;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    bus.dma_rd     = 1'b0;
    bus.dma_addr   = '0;
    bus.ppu_cs     = 1'b0;
    bus.ppu_rw     = 1'b1;
    bus.ppu_addr   = '0;
    bus.ppu_data_o = r_last_data;
    case (r_state)
      c_st_halt, c_st_align: begin
        bus.cpu_rdy = 1'b0;
        bus.busy    = 1'b1;
      end
      c_st_read: begin
        bus.cpu_rdy  = 1'b0;
        bus.busy     = 1'b1;
        bus.dma_rd   = 1'b1;
        bus.dma_addr = {r_page, r_cnt};
      end
      c_st_write: begin
        bus.cpu_rdy    = 1'b0;
        bus.busy       = 1'b1;
        bus.ppu_cs     = 1'b1;
        bus.ppu_rw     = 1'b0;
        bus.ppu_addr   = OAMDATA_IDX;
        bus.ppu_data_o = bus.dma_data_i;
      end
      c_st_done: bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_oam_dma.sv
`default_nettype none
// ============================================================================
//  Module      : tb_oam_dma
//  Description : Self-checking bench for oam_dma: cycle timeline model plus
//                directed transfers with hand-computed expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_oam_dma;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  oam_dma_if bus ();

  oam_dma #(
    .DMA_REG_ADDR (16'h4014),
    .OAMDATA_IDX  (3'd4),
    .XFER_LEN     (256)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory contents: page 0x02 holds 0..255 at offsets 0..255
  function automatic logic [7:0] memval(input logic [15:0] a);
    return a[7:0] ^ (a[15:8] - 8'h02);
  endfunction

  always @(posedge clk) if (bus.dma_rd) bus.dma_data_i <= memval(bus.dma_addr);

  // Timeline model: m_k is the cycle number since the accepted trigger
  // (1 = halt, optional align, then 512 alternating read/write, then done).
  int         m_k = 0, m_align = 0, m_cyc = 0, m_j = 0;
  logic [7:0] m_page = 8'h00, m_last = 8'h00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k = 0; m_align = 0; m_cyc = 0; m_last = 8'h00;
    end else begin
      m_j = m_k - 2 - m_align;
      if (m_k > 0 && m_j >= 0 && m_j < 512 && (m_j % 2) == 1)
        m_last = memval({m_page, 8'(m_j / 2)});
      if (m_k == 0) begin
        if (bus.cpu_wr && bus.cpu_addr == 16'h4014) begin
          m_k = 1; m_page = bus.cpu_data_i; m_align = m_cyc % 2;
        end
      end else if (m_k >= 514 + m_align) m_k = 0;
      else m_k++;
      m_cyc++;
    end
  end

  function automatic logic [32:0] model_out(input int k, input int al,
                                            input logic [7:0] pg, input logic [7:0] last);
    logic rdy = 1'b1, bsy = 1'b0, dn = 1'b0, rd = 1'b0, cs = 1'b0, rw = 1'b1;
    logic [15:0] a = 16'h0; logic [2:0] pa = 3'd0; logic [7:0] pd = last;
    int j = k - 2 - al;
    if (k >= 1) begin
      if (k <= 513 + al) begin rdy = 1'b0; bsy = 1'b1; end
      if (j >= 0 && j < 512) begin
        if (j % 2 == 0) begin rd = 1'b1; a = {pg, 8'(j / 2)}; end
        else begin cs = 1'b1; rw = 1'b0; pa = 3'd4; pd = memval({pg, 8'(j / 2)}); end
      end else if (j == 512) dn = 1'b1;
    end
    return {rdy, bsy, dn, rd, a, cs, rw, pa, pd};
  endfunction

  function automatic logic [32:0] dut_vec();
    return {bus.cpu_rdy, bus.busy, bus.done, bus.dma_rd, bus.dma_addr,
            bus.ppu_cs, bus.ppu_rw, bus.ppu_addr, bus.ppu_data_o};
  endfunction

  // Per-transfer observations used by the literal checks
  logic        prev_cs = 1'b0, first_rd_seen = 1'b0;
  int          halt_len = 0, cs_rises = 0, done_cnt = 0, seq_errs = 0, first_rd_par = 0;
  logic [15:0] first_rd_addr = 16'h0, last_rd_addr = 16'h0;
  logic [32:0] exp_v, act_v;

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      exp_v = model_out(m_k, m_align, m_page, m_last);
      act_v = dut_vec();
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL cycle_model t=%0t got=%h expected=%h", $time, act_v, exp_v);
      end
      if (!bus.cpu_rdy) halt_len++;
      if (bus.ppu_cs && !prev_cs) begin
        if (bus.ppu_data_o != 8'(cs_rises)) seq_errs++;
        cs_rises++;
      end
      if (bus.done) done_cnt++;
      if (bus.dma_rd) begin
        if (!first_rd_seen) begin
          first_rd_seen = 1'b1; first_rd_addr = bus.dma_addr; first_rd_par = m_cyc % 2;
        end
        last_rd_addr = bus.dma_addr;
      end
      prev_cs = bus.ppu_cs;
    end else prev_cs = 1'b0;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic clear_mon();
    halt_len = 0; cs_rises = 0; done_cnt = 0; seq_errs = 0; first_rd_seen = 1'b0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input logic wr);
    bus.cpu_addr = a; bus.cpu_data_i = d; bus.cpu_wr = wr;
    @(negedge clk);
    bus.cpu_addr = 16'h0; bus.cpu_data_i = 8'h00; bus.cpu_wr = 1'b0;
  endtask

  // par = required cycle parity of the trigger, or -1 for any
  task automatic trigger(input logic [7:0] pg, input int par);
    @(negedge clk);
    if (par >= 0) while (m_cyc % 2 != par) @(negedge clk);
    cpu_write(16'h4014, pg, 1'b1);
  endtask

  // Returns at the negedge inside the done cycle
  task automatic wait_done(input string name);
    for (int t = 0; t < 800 && done_cnt == 0; t++) @(negedge clk);
    check({name, "_done_seen"}, 64'(done_cnt), 64'd1);
  endtask

  localparam logic [32:0] c_rst_vec =
    {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 3'd0, 8'h00};

  initial begin
    bus.cpu_addr = 16'h0; bus.cpu_data_i = 8'h00; bus.cpu_wr = 1'b0; bus.dma_data_i = 8'h00;
    #2 rst_n = 1'b0;
    #1 check("reset_outputs", 64'(dut_vec()), 64'(c_rst_vec));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // 1: even-cycle trigger, page 0x02
    clear_mon(); trigger(8'h02, 0); wait_done("t1");
    repeat (4) @(negedge clk);
    check("t1_halt_len", 64'(halt_len), 64'd513);
    check("t1_cs_rises", 64'(cs_rises), 64'd256);
    check("t1_data_seq_errs", 64'(seq_errs), 64'd0);
    check("t1_first_rd_parity", 64'(first_rd_par), 64'd0);
    check("t1_first_rd_addr", 64'(first_rd_addr), 64'h0200);
    check("t1_single_done", 64'(done_cnt), 64'd1);

    // 2: odd-cycle trigger
    clear_mon(); trigger(8'h02, 1); wait_done("t2");
    repeat (3) @(negedge clk);
    check("t2_halt_len", 64'(halt_len), 64'd514);
    check("t2_first_rd_parity", 64'(first_rd_par), 64'd0);
    check("t2_cs_rises", 64'(cs_rises), 64'd256);
    check("t2_data_seq_errs", 64'(seq_errs), 64'd0);

    // 3: top page, plus a trigger coincident with done
    clear_mon(); trigger(8'hFF, -1); wait_done("t3");
    check("t3_last_rd_addr", 64'(last_rd_addr), 64'hFFFF);
    cpu_write(16'h4014, 8'h33, 1'b1);
    repeat (3) @(negedge clk);
    check("t3_trigger_at_done_ignored", 64'(bus.busy), 64'd0);
    clear_mon(); trigger(8'hFF, -1); wait_done("t3b");
    check("t3_restart_addr", 64'(first_rd_addr), 64'hFF00);

    // 4: second trigger mid-transfer
    repeat (2) @(negedge clk);
    clear_mon(); trigger(8'h02, -1);
    repeat (50) @(negedge clk);
    cpu_write(16'h4014, 8'h80, 1'b1);
    wait_done("t4");
    check("t4_cs_rises", 64'(cs_rises), 64'd256);
    check("t4_data_seq_errs", 64'(seq_errs), 64'd0);

    // 5: reset after 100 bytes
    repeat (2) @(negedge clk);
    clear_mon(); trigger(8'h02, -1);
    for (int t = 0; t < 400 && cs_rises < 100; t++) @(negedge clk);
    check("t5_reached_100", 64'(cs_rises), 64'd100);
    #2 rst_n = 1'b0;
    #1 check("t5_async_reset_outputs", 64'(dut_vec()), 64'(c_rst_vec));
    repeat (3) @(negedge clk);
    check("t5_no_done", 64'(done_cnt), 64'd0);
    rst_n = 1'b1;
    clear_mon(); trigger(8'h10, -1); wait_done("t5b");
    check("t5_restart_addr", 64'(first_rd_addr), 64'h1000);
    repeat (2) @(negedge clk);
    check("t5_restart_cs_rises", 64'(cs_rises), 64'd256);

    // 6: non-trigger accesses
    clear_mon();
    cpu_write(16'h4015, 8'h02, 1'b1);
    cpu_write(16'h4014, 8'h02, 1'b0);
    repeat (3) @(negedge clk);
    check("t6_busy", 64'(bus.busy), 64'd0);
    check("t6_no_reads", 64'(first_rd_seen), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule
`default_nettype wire
